// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: one capture per frame, show-ahead receive FIFO,
// sticky overrun flag and saturating parity/frame error counters.
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            rx_en,
  input  logic [DATA_BITS-1:0]            rx_data,
  input  logic                            data_ready,
  input  logic                            parity_err,
  input  logic                            frame_err,
  output logic [DATA_BITS-1:0]            m_data,
  output logic                            m_perr,
  output logic                            m_ferr,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overrun,
  output logic [7:0]                      perr_count,
  output logic [7:0]                      ferr_count,
  input  logic                            clear_status
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = 8;

  // Depth must be a power of two so the pointers wrap for free.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "uart_rx_ctrl: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef struct packed {
    logic                 perr;
    logic                 ferr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  entry_t          mem_q [FIFO_DEPTH];
  entry_t          mem_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            dr_q, dr_d;
  logic            m_valid_q, m_valid_d;
  entry_t          head_q, head_d;
  logic            overrun_q, overrun_d;
  logic [CW-1:0]   perr_q, perr_d;
  logic [CW-1:0]   ferr_q, ferr_d;

  logic            cap_c, pop_c, full_c, push_c, drop_c;
  entry_t          new_entry_c;

  // Next-state: edge-detected capture, FIFO push/pop, head register, status.
  always_comb begin
    dr_d        = data_ready;
    cap_c       = data_ready & ~dr_q & rx_en;
    pop_c       = m_valid_q & m_ready;
    full_c      = (level_q == LW'(FIFO_DEPTH));
    push_c      = cap_c & (~full_c | pop_c);
    drop_c      = cap_c & full_c & ~pop_c;
    new_entry_c = '{perr: parity_err, ferr: frame_err, data: rx_data};

    mem_d = mem_q;
    if (push_c) mem_d[wr_ptr_q] = new_entry_c;

    wr_ptr_d  = wr_ptr_q + PW'(push_c);
    rd_ptr_d  = rd_ptr_q + PW'(pop_c);
    level_d   = level_q + LW'(push_c) - LW'(pop_c);
    m_valid_d = (level_d != '0);
    head_d    = m_valid_d ? mem_d[rd_ptr_d] : '0;

    overrun_d = overrun_q | drop_c;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    if (cap_c && parity_err && (perr_q != {CW{1'b1}})) perr_d = perr_q + CW'(1);
    if (cap_c && frame_err  && (ferr_q != {CW{1'b1}})) ferr_d = ferr_q + CW'(1);
    if (clear_status) begin
      overrun_d = 1'b0;
      perr_d    = '0;
      ferr_d    = '0;
    end
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dr_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      m_valid_q <= 1'b0;
      head_q    <= '0;
      overrun_q <= 1'b0;
      perr_q    <= '0;
      ferr_q    <= '0;
    end else begin
      dr_q      <= dr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      m_valid_q <= m_valid_d;
      head_q    <= head_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // Storage array; contents are don't-care while not covered by level_q.
  always_ff @(posedge clk) begin
    if (resetn) mem_q <= mem_d;
  end

  assign m_data     = head_q.data;
  assign m_perr     = head_q.perr;
  assign m_ferr     = head_q.ferr;
  assign m_valid    = m_valid_q;
  assign fifo_level = level_q;
  assign overrun    = overrun_q;
  assign perr_count = perr_q;
  assign ferr_count = ferr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a randomized
// phase, all compared against a queue-based behavioural model.
module tb_uart_rx_ctrl;

  localparam int DB    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn, rx_en, data_ready, parity_err, frame_err;
  logic [DB-1:0] rx_data;
  logic [DB-1:0] m_data;
  logic          m_perr, m_ferr, m_valid, m_ready;
  logic [2:0]    fifo_level;
  logic          overrun, clear_status;
  logic [7:0]    perr_count, ferr_count;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .rx_en(rx_en), .rx_data(rx_data),
    .data_ready(data_ready), .parity_err(parity_err), .frame_err(frame_err),
    .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr), .m_valid(m_valid),
    .m_ready(m_ready), .fifo_level(fifo_level), .overrun(overrun),
    .perr_count(perr_count), .ferr_count(ferr_count), .clear_status(clear_status)
  );

  // Reference model: a queue of received frames plus plain integer status.
  typedef struct { bit pe; bit fe; bit [DB-1:0] d; } ent_t;
  ent_t mq[$];
  int   mdl_perr, mdl_ferr;
  bit   mdl_ovr, mdl_dr_prev;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently being driven.
  task automatic model_update();
    bit new_frame, popped, was_full;
    if (!resetn) begin
      mq.delete();
      mdl_perr = 0; mdl_ferr = 0; mdl_ovr = 0; mdl_dr_prev = 1;
      return;
    end
    new_frame = data_ready && !mdl_dr_prev && rx_en;
    was_full  = (mq.size() == DEPTH);
    popped    = (mq.size() > 0) && m_ready;
    if (popped) void'(mq.pop_front());
    if (new_frame) begin
      if (!was_full || popped) mq.push_back('{parity_err, frame_err, rx_data});
      else mdl_ovr = 1;
      if (parity_err) mdl_perr = (mdl_perr >= 255) ? 255 : mdl_perr + 1;
      if (frame_err)  mdl_ferr = (mdl_ferr >= 255) ? 255 : mdl_ferr + 1;
    end
    if (clear_status) begin
      mdl_ovr = 0; mdl_perr = 0; mdl_ferr = 0;
    end
    mdl_dr_prev = data_ready;
  endtask

  task automatic check_model();
    chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    if (mq.size() != 0) begin
      chk("m_data", 32'(m_data), 32'(mq[0].d));
      chk("m_perr", 32'(m_perr), 32'(mq[0].pe));
      chk("m_ferr", 32'(m_ferr), 32'(mq[0].fe));
    end
    chk("overrun", 32'(overrun), 32'(mdl_ovr));
    chk("perr_count", 32'(perr_count), 32'(mdl_perr));
    chk("ferr_count", 32'(ferr_count), 32'(mdl_ferr));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // One frame: data_ready held for 'hold' cycles, then low for one cycle.
  task automatic frame(input logic [DB-1:0] d, input logic pe, input logic fe, input int hold);
    rx_data = d; parity_err = pe; frame_err = fe; data_ready = 1'b1;
    repeat (hold) step();
    data_ready = 1'b0;
    step();
  endtask

  initial begin
    resetn = 0; rx_en = 0; rx_data = '0; data_ready = 1; parity_err = 0;
    frame_err = 0; m_ready = 0; clear_status = 0;
    mdl_dr_prev = 1; mdl_perr = 0; mdl_ferr = 0; mdl_ovr = 0;

    // Reset state with data_ready already high
    step(); step();
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_level", 32'(fifo_level), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_perr", 32'(perr_count), 32'h0);
    chk("rst_ferr", 32'(ferr_count), 32'h0);

    // data_ready held across reset release: no capture
    rx_en = 1; resetn = 1; rx_data = 8'hC3;
    repeat (5) step();
    chk("no_cap_after_reset", 32'(m_valid), 32'h0);

    // Long data_ready pulse: exactly one entry
    data_ready = 0; step();
    rx_data = 8'h5A; data_ready = 1; step();
    chk("long_dr_valid", 32'(m_valid), 32'h1);
    chk("long_dr_data", 32'(m_data), 32'h5A);
    repeat (15) step();
    chk("long_dr_level", 32'(fifo_level), 32'h1);
    data_ready = 0; step();
    m_ready = 1; step(); m_ready = 0;
    chk("drain_one_level", 32'(fifo_level), 32'h0);

    // Five frames into a depth-4 buffer: overrun, first four kept in order
    for (int i = 1; i <= 5; i++) frame(DB'(i), 1'b0, 1'b0, 2);
    chk("ovf_level", 32'(fifo_level), 32'h4);
    chk("ovf_overrun", 32'(overrun), 32'h1);
    m_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain_order", 32'(m_data), 32'(i));
      step();
    end
    m_ready = 0;
    chk("ovf_drained", 32'(m_valid), 32'h0);
    clear_status = 1; step(); clear_status = 0;
    chk("ovf_cleared", 32'(overrun), 32'h0);

    // Full buffer, capture coincident with pop
    for (int i = 0; i < 4; i++) frame(DB'(8'h11 + i), 1'b0, 1'b0, 1);
    chk("full_level", 32'(fifo_level), 32'h4);
    rx_data = 8'h15; data_ready = 1; m_ready = 1; step();
    data_ready = 0; m_ready = 0;
    chk("pushpop_level", 32'(fifo_level), 32'h4);
    chk("pushpop_overrun", 32'(overrun), 32'h0);
    chk("pushpop_head", 32'(m_data), 32'h12);
    m_ready = 1; repeat (3) step();
    chk("pushpop_last", 32'(m_data), 32'h15);
    step(); m_ready = 0;
    chk("pushpop_empty", 32'(fifo_level), 32'h0);

    // 300 parity-error frames: saturation, then clear
    for (int i = 0; i < 300; i++) frame(DB'($urandom), 1'b1, 1'b0, 1);
    chk("sat_perr", 32'(perr_count), 32'd255);
    chk("sat_ferr", 32'(ferr_count), 32'd0);
    chk("sat_overrun", 32'(overrun), 32'h1);
    clear_status = 1; step(); clear_status = 0;
    chk("clr_perr", 32'(perr_count), 32'd0);
    chk("clr_ferr", 32'(ferr_count), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'h0);
    chk("clr_keeps_buffer", 32'(fifo_level), 32'h4);
    m_ready = 1; repeat (4) step(); m_ready = 0;

    // rx_en low suppresses capture; enabling mid-frame still does not capture
    rx_en = 0;
    frame(8'h77, 1'b1, 1'b1, 3);
    chk("rxen0_level", 32'(fifo_level), 32'h0);
    chk("rxen0_perr", 32'(perr_count), 32'd0);
    chk("rxen0_ferr", 32'(ferr_count), 32'd0);
    rx_data = 8'h66; data_ready = 1; step();
    rx_en = 1; repeat (3) step();
    chk("rxen_late_level", 32'(fifo_level), 32'h0);
    data_ready = 0; step();

    // Reset mid-operation with a coincident capture
    frame(8'hA1, 1'b0, 1'b1, 1);
    frame(8'hA2, 1'b1, 1'b0, 1);
    rx_data = 8'hA3; data_ready = 1; resetn = 0; step();
    resetn = 1; data_ready = 0; step();
    chk("midrst_level", 32'(fifo_level), 32'h0);
    chk("midrst_valid", 32'(m_valid), 32'h0);
    chk("midrst_ferr", 32'(ferr_count), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) data_ready = ~data_ready;
      rx_en        = ($urandom_range(0, 7) != 0);
      rx_data      = DB'($urandom);
      parity_err   = ($urandom_range(0, 3) == 0);
      frame_err    = ($urandom_range(0, 3) == 0);
      m_ready      = ($urandom_range(0, 2) == 0);
      clear_status = ($urandom_range(0, 99) == 0);
      resetn       = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: width of received data word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of receive-buffer entries, a power of 2 and at least 2; any other value SHALL stop elaboration with a fatal error.
REQ-003 SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_en  input  1  capture enable.
REQ-006 SHALL have port rx_data  input  DATA_BITS  received word from the receiver.
REQ-007 SHALL have port data_ready  input  1  receiver frame-complete level, held high for 1 or more clk cycles.
REQ-008 SHALL have port parity_err  input  1  parity error of the current frame, valid while data_ready=1.
REQ-009 SHALL have port frame_err  input  1  stop-bit error of the current frame, valid while data_ready=1.
REQ-010 SHALL have port m_data  output  DATA_BITS  head-of-buffer word.
REQ-011 SHALL have port m_perr  output  1  parity_err flag of the head entry.
REQ-012 SHALL have port m_ferr  output  1  frame_err flag of the head entry.
REQ-013 SHALL have port m_valid  output  1  buffer not empty.
REQ-014 SHALL have port m_ready  input  1  consumer accept.
REQ-015 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of buffered entries.
REQ-016 SHALL have port overrun  output  1  sticky flag: a frame was dropped.
REQ-017 SHALL have port perr_count  output  8  saturating count of frames with parity errors.
REQ-018 SHALL have port ferr_count  output  8  saturating count of frames with frame errors.
REQ-019 SHALL have port clear_status  input  1  single-cycle clear of overrun and both counters.

Function
REQ-020 SHALL register data_ready into dr_q each cycle; capture event = data_ready & ~dr_q & rx_en, so at most 1 capture per frame regardless of how long data_ready is held.
REQ-021 On a capture event, SHALL push the entry {parity_err, frame_err, rx_data} as sampled in that cycle; the entry SHALL appear on m_* with m_valid=1 on the following cycle when the buffer was empty.
REQ-022 SHALL present the buffer show-ahead: m_data, m_perr and m_ferr SHALL equal the head entry whenever m_valid=1; pop = m_valid & m_ready; m_* SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 Push with buffer not full: SHALL accept the entry and increment fifo_level.
REQ-024 Push with buffer full and no pop in the same cycle: SHALL discard the entry, leave buffer contents unchanged, and set overrun=1 from the next cycle.
REQ-025 Push and pop in the same cycle: SHALL accept both, including when the buffer is full, and leave fifo_level unchanged.
REQ-026 Pop while the buffer is empty: SHALL have no effect, since m_valid=0.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL range from 0 to FIFO_DEPTH.
REQ-028 On every capture event, including dropped frames, SHALL increment perr_count when parity_err=1 and ferr_count when frame_err=1, each saturating at 255.
REQ-029 clear_status=1 SHALL zero overrun, perr_count and ferr_count on the next cycle, taking priority over any coincident set or increment; buffer contents SHALL be unaffected.
REQ-030 rx_en=0 SHALL suppress capture only; pop, counters and clear SHALL continue to operate.
REQ-031 If rx_en rises while data_ready is already high, SHALL NOT capture that frame.

Reset
REQ-032 resetn=0 at a clk edge SHALL empty the buffer and set m_valid=0, fifo_level=0, m_data=0, m_perr=0, m_ferr=0, overrun=0, perr_count=0, ferr_count=0.
REQ-033 Reset SHALL set dr_q=1, so a data_ready held high across reset release SHALL NOT cause a capture.
REQ-034 Reset asserted mid-operation SHALL discard all buffered entries, and any capture in that cycle SHALL be lost.

Verification
REQ-035 Bench SHALL cover: data_ready high for 16 cycles with rx_data=0x5A, rx_en=1, m_ready=0 -> exactly 1 entry, m_data=0x5A on the next cycle, fifo_level=1.
REQ-036 Bench SHALL cover: 5 frames 0x01..0x05 with m_ready=0 and FIFO_DEPTH=4 -> fifo_level=4, overrun=1, drain yields 0x01..0x04 in order.
REQ-037 Bench SHALL cover: buffer full and a capture coincident with a pop -> fifo_level stays 4, overrun stays 0, new word becomes last entry.
REQ-038 Bench SHALL cover: 300 frames with parity_err=1 and frame_err=0 -> perr_count=255, ferr_count=0; then clear_status -> both 0 and overrun 0 next cycle.
REQ-039 Bench SHALL cover: data_ready=1 during and after reset release -> no capture, m_valid=0 until the next data_ready rising edge.
REQ-040 Bench SHALL cover: rx_en=0 during a frame -> no push, counters unchanged; rx_en=1 with data_ready high -> still no capture.
